// File: rtl/nlc_fpu_pkg.sv
// nlc_fpu_pkg: shared defaults, op codes and lane state encoding for the FPU arbiter
package nlc_fpu_pkg;
  localparam int DEF_NREQ = 4;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_TIMEOUT = 64;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;
  typedef enum logic [1:0] {LANE_IDLE, LANE_ISSUE, LANE_WAIT, LANE_RESP} lane_state_t;
endpackage

// File: rtl/nlc_fpu_arbiter_if.sv
// nlc_fpu_arbiter_if: requester bus, response bus and both FPU unit handshakes
interface nlc_fpu_arbiter_if
  import nlc_fpu_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
);
  logic [NREQ-1:0] req_valid, req_op, req_grant, rsp_valid, rsp_err;
  logic [NREQ*WIDTH-1:0] req_x, req_y, rsp_z;
  logic [WIDTH-1:0] add_x, add_y, add_z, mul_x, mul_y, mul_z;
  logic add_srdyi, add_srdyo, mul_srdyi, mul_srdyo, busy;
  modport slave (
    input req_valid, req_op, req_x, req_y, add_z, add_srdyo, mul_z, mul_srdyo,
    output req_grant, rsp_valid, rsp_err, rsp_z, add_x, add_y, add_srdyi, mul_x, mul_y, mul_srdyi, busy
  );
  modport master (
    output req_valid, req_op, req_x, req_y, add_z, add_srdyo, mul_z, mul_srdyo,
    input req_grant, rsp_valid, rsp_err, rsp_z, add_x, add_y, add_srdyi, mul_x, mul_y, mul_srdyi, busy
  );
endinterface

// File: rtl/nlc_fpu_lane.sv
// nlc_fpu_lane: one FPU lane - round-robin pick, operand capture, issue, bounded wait, response
module nlc_fpu_lane
  import nlc_fpu_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       i_elig,
  input  logic [NREQ*WIDTH-1:0] i_x,
  input  logic [NREQ*WIDTH-1:0] i_y,
  input  logic                  i_srdyo,
  output logic [WIDTH-1:0]      o_x,
  output logic [WIDTH-1:0]      o_y,
  output logic                  o_srdyi,
  output logic [NREQ-1:0]       o_take,
  output logic [NREQ-1:0]       o_grant,
  output logic [NREQ-1:0]       o_rsp,
  output logic [IW-1:0]         o_own,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  lane_state_t r_state, w_next;
  logic [IW-1:0] r_ptr, r_own, w_win;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_x, r_y, w_x, w_y;
  logic [NREQ-1:0] r_grant;
  logic r_srdyi, w_found;
  assign o_x = r_x;
  assign o_y = r_y;
  assign o_srdyi = r_srdyi;
  assign o_grant = r_grant;
  assign o_own = r_own;
  // lowest eligible at or above the pointer wins, else wrap to the lowest eligible overall
  always_comb begin
    w_found = 1'b0;
    w_win = '0;
    w_x = '0;
    w_y = '0;
    for (int k = NREQ - 1; k >= 0; k--) if (i_elig[k]) begin
      w_found = 1'b1;
      w_win = IW'(k);
    end
    for (int k = NREQ - 1; k >= 0; k--) if (i_elig[k] && IW'(k) >= r_ptr) w_win = IW'(k);
    for (int k = 0; k < NREQ; k++) if (w_win == IW'(k)) begin
      w_x = i_x[k*WIDTH +: WIDTH];
      w_y = i_y[k*WIDTH +: WIDTH];
    end
  end
  always_comb begin
    o_done = r_state == LANE_WAIT && (i_srdyo || r_cnt == CW'(TIMEOUT));
    o_err = o_done && !i_srdyo;
    o_busy = r_state != LANE_IDLE;
    o_take = (r_state == LANE_IDLE && w_found) ? NREQ'(1) << w_win : '0;
    o_rsp = (r_state == LANE_RESP) ? NREQ'(1) << r_own : '0;
    w_next = (r_state == LANE_IDLE && w_found) ? LANE_ISSUE :
             (r_state == LANE_ISSUE) ? LANE_WAIT :
             o_done ? LANE_RESP :
             (r_state == LANE_RESP) ? LANE_IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LANE_IDLE;
      r_ptr <= '0;
      r_own <= '0;
      r_cnt <= '0;
      r_x <= '0;
      r_y <= '0;
      r_srdyi <= 1'b0;
      r_grant <= '0;
    end else begin
      r_state <= w_next;
      r_srdyi <= r_state == LANE_ISSUE;
      r_grant <= o_take;
      r_cnt <= (r_state == LANE_ISSUE) ? CW'(1) : (r_state == LANE_WAIT && w_next == LANE_WAIT) ? r_cnt + 1'b1 : '0;
      if (o_take != '0) begin
        r_own <= w_win;
        r_ptr <= (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
        r_x <= w_x;
        r_y <= w_y;
      end
    end
  end
endmodule

// File: rtl/nlc_fpu_arbiter.sv
// nlc_fpu_arbiter: shares one adder and one multiplier among NREQ requesters via two lanes
module nlc_fpu_arbiter
  import nlc_fpu_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic clk,
  input logic reset,
  nlc_fpu_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [NREQ-1:0] r_pend, r_err, w_elig_add, w_elig_mul, w_take_add, w_take_mul;
  logic [NREQ-1:0] w_grant_add, w_grant_mul, w_rsp_add, w_rsp_mul;
  logic [NREQ*WIDTH-1:0] r_z;
  logic [IW-1:0] w_own_add, w_own_mul;
  logic w_done_add, w_done_mul, w_err_add, w_err_mul, w_busy_add, w_busy_mul;
  // a requester with anything in flight is invisible to both lanes
  assign w_elig_add = bus.req_valid & ~r_pend & ~(bus.req_op ^ {NREQ{OP_ADD}});
  assign w_elig_mul = bus.req_valid & ~r_pend & ~(bus.req_op ^ {NREQ{OP_MUL}});
  assign bus.req_grant = w_grant_add | w_grant_mul;
  assign bus.rsp_valid = w_rsp_add | w_rsp_mul;
  assign bus.rsp_err = r_err;
  assign bus.rsp_z = r_z;
  assign bus.busy = w_busy_add | w_busy_mul;
  nlc_fpu_lane #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) u_add (
    .clk(clk), .reset(reset), .i_elig(w_elig_add), .i_x(bus.req_x), .i_y(bus.req_y),
    .i_srdyo(bus.add_srdyo), .o_x(bus.add_x), .o_y(bus.add_y), .o_srdyi(bus.add_srdyi),
    .o_take(w_take_add), .o_grant(w_grant_add), .o_rsp(w_rsp_add), .o_own(w_own_add),
    .o_done(w_done_add), .o_err(w_err_add), .o_busy(w_busy_add)
  );
  nlc_fpu_lane #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) u_mul (
    .clk(clk), .reset(reset), .i_elig(w_elig_mul), .i_x(bus.req_x), .i_y(bus.req_y),
    .i_srdyo(bus.mul_srdyo), .o_x(bus.mul_x), .o_y(bus.mul_y), .o_srdyi(bus.mul_srdyi),
    .o_take(w_take_mul), .o_grant(w_grant_mul), .o_rsp(w_rsp_mul), .o_own(w_own_mul),
    .o_done(w_done_mul), .o_err(w_err_mul), .o_busy(w_busy_mul)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
      r_err <= '0;
      r_z <= '0;
    end else begin
      r_pend <= (r_pend | w_take_add | w_take_mul) & ~(w_rsp_add | w_rsp_mul);
      for (int k = 0; k < NREQ; k++) begin
        if (w_done_add && w_own_add == IW'(k)) begin
          r_z[k*WIDTH +: WIDTH] <= w_err_add ? '0 : bus.add_z;
          r_err[k] <= w_err_add;
        end
        if (w_done_mul && w_own_mul == IW'(k)) begin
          r_z[k*WIDTH +: WIDTH] <= w_err_mul ? '0 : bus.mul_z;
          r_err[k] <= w_err_mul;
        end
      end
    end
  end
endmodule

// File: tb/tb_nlc_fpu_arbiter.sv
// tb_nlc_fpu_arbiter: directed checks of grant, issue, response, timeout, reset and pending rules
module tb_nlc_fpu_arbiter;
  import nlc_fpu_pkg::*;
  localparam int N = 4;
  localparam int W = 32;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  nlc_fpu_arbiter_if #(.NREQ(N), .WIDTH(W)) bus ();
  nlc_fpu_arbiter #(.NREQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  // unit stubs: latency L counts the srdyi cycle itself, so srdyo is high L-1 cycles after srdyi
  int a_lat = 5, m_lat = 3, a_cnt = 0, m_cnt = 0;
  logic [W-1:0] a_val = '0, m_val = '0, a_z, m_z;
  logic a_so, m_so, m_never = 1'b0, m_late = 1'b0;
  assign bus.add_z = a_z;
  assign bus.add_srdyo = a_so;
  assign bus.mul_z = m_z;
  assign bus.mul_srdyo = m_so | m_late;
  always @(posedge clk) begin
    if (reset) begin
      a_cnt <= 0; a_so <= 1'b0; a_z <= '0;
      m_cnt <= 0; m_so <= 1'b0; m_z <= '0;
    end else begin
      a_so <= a_cnt == 1;
      a_z <= (a_cnt == 1) ? a_val : '0;
      a_cnt <= bus.add_srdyi ? a_lat - 2 : (a_cnt != 0 ? a_cnt - 1 : 0);
      m_so <= m_cnt == 1 && !m_never;
      m_z <= (m_cnt == 1) ? m_val : '0;
      m_cnt <= bus.mul_srdyi ? m_lat - 2 : (m_cnt != 0 ? m_cnt - 1 : 0);
    end
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic req(input int i, input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.req_valid[i] = 1'b1;
    bus.req_op[i] = op;
    bus.req_x[i*W +: W] = x;
    bus.req_y[i*W +: W] = y;
  endtask
  task automatic wait_idle;
    for (int c = 0; c < 300 && bus.busy; c++) tick;
    chk("idle", bus.busy, 1'b0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int got[$];
    int n, seen, t_rsp, t_gnt, t_si;
    bus.req_valid = '0; bus.req_op = '0; bus.req_x = '0; bus.req_y = '0;
    tick; tick;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_grant", bus.req_grant, 4'b0);
    chk("rst_rspv", bus.rsp_valid, 4'b0);
    chk("rst_rspz", bus.rsp_z, '0);
    chk("rst_srdyi", {bus.add_srdyi, bus.mul_srdyi}, 2'b0);
    reset = 1'b0;
    // single add on requester 2
    a_lat = 5; a_val = 32'h40400000;
    req(2, OP_ADD, 32'h3F800000, 32'h40000000);
    tick;
    chk("t1_grant", bus.req_grant, 4'b0100);
    bus.req_valid = '0;
    tick;
    chk("t1_srdyi", bus.add_srdyi, 1'b1);
    chk("t1_ops", {bus.add_x, bus.add_y}, {32'h3F800000, 32'h40000000});
    chk("t1_mulidle", bus.mul_srdyi, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick;
      chk("t1_norsp", bus.rsp_valid, 4'b0);
    end
    tick;
    chk("t1_rspv", bus.rsp_valid, 4'b0100);
    chk("t1_rspz", bus.rsp_z[2*W +: W], 32'h40400000);
    chk("t1_err", bus.rsp_err, 4'b0);
    tick;
    chk("t1_drop", bus.rsp_valid, 4'b0);
    chk("t1_hold", bus.rsp_z[2*W +: W], 32'h40400000);
    chk("t1_busy", bus.busy, 1'b0);
    // fairness: all four hold a multiply request
    m_lat = 3; m_val = 32'h5;
    for (int i = 0; i < N; i++) req(i, OP_MUL, i, i + 1);
    for (int c = 0; c < 200 && got.size() < 5; c++) begin
      tick;
      for (int i = 0; i < N; i++) if (bus.req_grant[i]) got.push_back(i);
    end
    bus.req_valid = '0;
    for (int k = 0; k < 5; k++) chk($sformatf("fair_%0d", k), (k < got.size()) ? got[k] : -1, k % N);
    wait_idle;
    // concurrent add and multiply with simultaneous responses
    a_lat = 3; m_lat = 3; a_val = 32'h11111111; m_val = 32'h22222222;
    req(0, OP_ADD, 32'hA, 32'hB);
    req(1, OP_MUL, 32'hC, 32'hD);
    tick;
    chk("t3_grant", bus.req_grant, 4'b0011);
    bus.req_valid = '0;
    tick;
    chk("t3_srdyi", {bus.add_srdyi, bus.mul_srdyi}, 2'b11);
    chk("t3_ops", {bus.add_x, bus.mul_y}, {32'hA, 32'hD});
    tick;
    tick;
    chk("t3_norsp", bus.rsp_valid, 4'b0);
    tick;
    chk("t3_rspv", bus.rsp_valid, 4'b0011);
    chk("t3_z0", bus.rsp_z[0 +: W], 32'h11111111);
    chk("t3_z1", bus.rsp_z[W +: W], 32'h22222222);
    chk("t3_err", bus.rsp_err[1:0], 2'b00);
    wait_idle;
    // multiplier never answers; late srdyo afterwards must be ignored
    m_never = 1'b1;
    req(1, OP_MUL, 32'h1, 32'h2);
    tick;
    bus.req_valid = '0;
    tick;
    n = 0;
    for (int c = 0; c < 200; c++) begin
      tick;
      n++;
      if (bus.rsp_valid != '0) break;
    end
    chk("to_cycles", n, TO);
    chk("to_rspv", bus.rsp_valid, 4'b0010);
    chk("to_err", bus.rsp_err[1], 1'b1);
    chk("to_z", bus.rsp_z[W +: W], 32'h0);
    tick;
    m_late = 1'b1;
    tick;
    m_late = 1'b0;
    chk("late_rspv", bus.rsp_valid, 4'b0);
    chk("late_z", {bus.rsp_err[1], bus.rsp_z[W +: W]}, {1'b1, 32'h0});
    tick;
    chk("late_quiet", {bus.busy, bus.rsp_valid}, 5'b0);
    m_never = 1'b0;
    // reset while the adder lane waits
    a_lat = 20;
    req(2, OP_ADD, 32'h7, 32'h8);
    tick;
    chk("rw_grant", bus.req_grant, 4'b0100);
    bus.req_valid = '0;
    repeat (4) tick;
    chk("rw_busy", bus.busy, 1'b1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rw_out", {bus.req_grant, bus.rsp_valid, bus.rsp_err, bus.busy, bus.add_srdyi}, '0);
    chk("rw_rspz", bus.rsp_z, '0);
    chk("rw_ops", {bus.add_x, bus.add_y}, '0);
    seen = 0;
    repeat (30) begin
      tick;
      if (bus.rsp_valid != '0) seen++;
    end
    chk("rw_norsp", seen, 0);
    a_lat = 3;
    req(0, OP_ADD, 32'h1, 32'h1);
    req(3, OP_ADD, 32'h2, 32'h2);
    tick;
    chk("rw_ptr0", bus.req_grant, 4'b0001);
    bus.req_valid = '0;
    wait_idle;
    // requester 3 switches to a multiply request while its add is pending
    a_lat = 6; m_lat = 3;
    req(3, OP_ADD, 32'h3, 32'h4);
    tick;
    chk("pb_grant", bus.req_grant, 4'b1000);
    bus.req_op[3] = OP_MUL;
    t_rsp = -1; t_gnt = -1; t_si = -1;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (bus.rsp_valid[3] && t_rsp < 0) t_rsp = c;
      if (bus.req_grant[3] && t_gnt < 0) t_gnt = c;
      if (bus.mul_srdyi && t_si < 0) t_si = c;
    end
    bus.req_valid = '0;
    chk("pb_rsp", t_rsp, 7);
    chk("pb_mulgrant", t_gnt, 9);
    chk("pb_mulsrdyi", t_si, 10);
    wait_idle;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
